// File: rtl/intersection_pkg.sv
// Shared types and constants for the actuated intersection scheduler.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
// Contents: phase state enum, one-hot light codes {red, yellow, green},
// and the Moore light decode used by the scheduler's registered outputs.
package intersection_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    A_CLEAR  = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    B_CLEAR  = 3'd5,
    PED_WALK = 3'd6
  } state_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } lights_t;

  // Clear, walk and any unlisted encoding show red on both roads.
  function automatic lights_t decode_lights(input state_e s);
    lights_t l;
    l.a = LIGHT_RED;
    l.b = LIGHT_RED;
    case (s)
      A_GREEN:  l.a = LIGHT_GREEN;
      A_YELLOW: l.a = LIGHT_YELLOW;
      B_GREEN:  l.b = LIGHT_GREEN;
      B_YELLOW: l.b = LIGHT_YELLOW;
      default:  ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter with clear, increment, saturation and terminal compare.
// Latency: count updates one cycle after clr/inc are sampled; term is combinational from count.
// Backpressure: none; clr has priority over inc, saturation holds count at sat_val.
// Ports: clock, reset (async, active-high), clr, inc, sat_en, sat_val,
// term_val in; count (registered) and term (count == term_val) out.
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] sat_val,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(sat_en && (count_q == sat_val))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == term_val);

endmodule

// File: rtl/intersection_scheduler.sv
// Demand-actuated two-road phase scheduler with optional pedestrian walk phase.
// Latency: inputs sampled at edge n change registered outputs right after edge n.
// Backpressure: none; car inputs are levels, ped_req pulses are latched until served.
// Ports: clock, reset (async, active-high), car_A, car_B, ped_req in;
// light_A/light_B ({red,yellow,green} one-hot), walk, ped_pending, phase,
// counter out. Macro PED_CROSSING_EN enables the pedestrian features;
// without it ped_req is ignored, walk/ped_pending stay 0 and PED_WALK
// is an illegal state that recovers to A_CLEAR.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned WALK      = 6,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             car_A,
  input  logic             car_B,
  input  logic             ped_req,
  output logic [2:0]       light_A,
  output logic [2:0]       light_B,
  output logic             walk,
  output logic             ped_pending,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] counter
);

`ifdef PED_CROSSING_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] GMIN_T = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_T = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_T  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK - 1);

  state_e           state_q, state_d;
  logic             last_green_q, last_green_d;  // 0 = road A, 1 = road B
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic [2:0]       light_a_q, light_b_q;
  lights_t          lights_d;

  logic             sat_en, term;
  logic [CNT_W-1:0] term_val, count;
  logic             demand_a, demand_b;

  // Demand to leave a road's green: cross-road traffic or a waiting pedestrian.
  assign demand_a = car_B | ped_pend_q;
  assign demand_b = car_A | ped_pend_q;

  always_comb begin
    state_d  = state_q;
    term_val = '0;
    sat_en   = 1'b0;
    case (state_q)
      A_GREEN: begin
        sat_en   = 1'b1;
        term_val = GMAX_T;
        if ((count >= GMIN_T) && demand_a && (!car_A || term)) state_d = A_YELLOW;
      end
      A_YELLOW: begin
        term_val = YEL_T;
        if (term) state_d = A_CLEAR;
      end
      A_CLEAR: begin
        term_val = RED_T;
        if (term) state_d = ped_pend_q ? PED_WALK : B_GREEN;
      end
      B_GREEN: begin
        sat_en   = 1'b1;
        term_val = GMAX_T;
        if ((count >= GMIN_T) && demand_b && (!car_B || term)) state_d = B_YELLOW;
      end
      B_YELLOW: begin
        term_val = YEL_T;
        if (term) state_d = B_CLEAR;
      end
      B_CLEAR: begin
        term_val = RED_T;
        if (term) state_d = ped_pend_q ? PED_WALK : A_GREEN;
      end
      PED_WALK: begin
        term_val = WALK_T;
        if (!PED_EN) state_d = A_CLEAR;
        else if (term) state_d = last_green_q ? A_GREEN : B_GREEN;
      end
      default: state_d = A_CLEAR;
    endcase
  end

  always_comb begin
    last_green_d = last_green_q;
    if (state_d == A_GREEN) last_green_d = 1'b0;
    if (state_d == B_GREEN) last_green_d = 1'b1;

    // Entry into the walk phase clears the latch and beats a same-cycle set.
    ped_pend_d = ped_pend_q;
    if (ped_req && (state_q != PED_WALK)) ped_pend_d = 1'b1;
    if ((state_d == PED_WALK) && (state_q != PED_WALK)) ped_pend_d = 1'b0;
    if (!PED_EN) ped_pend_d = 1'b0;

    walk_d   = PED_EN && (state_d == PED_WALK);
    lights_d = decode_lights(state_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= A_GREEN;
      last_green_q <= 1'b0;
      ped_pend_q   <= 1'b0;
      walk_q       <= 1'b0;
      light_a_q    <= LIGHT_GREEN;
      light_b_q    <= LIGHT_RED;
    end else begin
      state_q      <= state_d;
      last_green_q <= last_green_d;
      ped_pend_q   <= ped_pend_d;
      walk_q       <= walk_d;
      light_a_q    <= lights_d.a;
      light_b_q    <= lights_d.b;
    end
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clr      (state_d != state_q),
    .inc      (1'b1),
    .sat_en   (sat_en),
    .sat_val  (GMAX_T),
    .term_val (term_val),
    .count    (count),
    .term     (term)
  );

  assign light_A     = light_a_q;
  assign light_B     = light_b_q;
  assign walk        = walk_q;
  assign ped_pending = ped_pend_q;
  assign phase       = state_q;
  assign counter     = count;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: directed scenarios push
// expected (cycle, phase, counter, ped_pending) entries; a negedge monitor
// pops and compares them, deriving light/walk expectations from the phase.
module tb_intersection_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       car_A, car_B, ped_req;
  logic [2:0] light_A, light_B, phase;
  logic       walk, ped_pending;
  logic [4:0] counter;

  intersection_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .car_A       (car_A),
    .car_B       (car_B),
    .ped_req     (ped_req),
    .light_A     (light_A),
    .light_B     (light_B),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase),
    .counter     (counter)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0] name;
    int          cyc;
    logic        now;
    logic [2:0]  ph;
    logic [4:0]  cnt;
    logic        pp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Rising edges since reset release.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  function automatic logic [5:0] lights_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 6'b001_100;
      3'd1:    return 6'b010_100;
      3'd3:    return 6'b100_001;
      3'd4:    return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic compare(input exp_t e);
    logic [5:0] l;
    logic       w;
    l = lights_for(e.ph);
    w = (e.ph == 3'd6);
    checks++;
    if (phase !== e.ph || counter !== e.cnt || light_A !== l[5:3] ||
        light_B !== l[2:0] || walk !== w || ped_pending !== e.pp) begin
      errors++;
      $display("FAIL %s cyc=%0d got ph=%0d cnt=%0d A=%b B=%b walk=%b pp=%b want ph=%0d cnt=%0d A=%b B=%b walk=%b pp=%b",
               e.name, cyc, phase, counter, light_A, light_B, walk, ped_pending,
               e.ph, e.cnt, l[5:3], l[2:0], w, e.pp);
    end
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0 && (sb[0].now || sb[0].cyc == cyc)) begin
      mon_e = sb.pop_front();
      compare(mon_e);
    end
    if (sb.size() > 0 && !sb[0].now && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", mon_e.name, mon_e.cyc, cyc);
    end
  end

  task automatic push(input logic [63:0] nm, input int c, input logic [2:0] ph,
                      input int cnt, input logic pp);
    exp_t e;
    e.name = nm; e.cyc = c; e.now = 1'b0; e.ph = ph; e.cnt = 5'(cnt); e.pp = pp;
    sb.push_back(e);
  endtask

  task automatic push_now(input logic [63:0] nm, input logic [2:0] ph,
                          input int cnt, input logic pp);
    exp_t e;
    e.name = nm; e.cyc = 0; e.now = 1'b1; e.ph = ph; e.cnt = 5'(cnt); e.pp = pp;
    sb.push_back(e);
  endtask

  // Advances to 1 time unit after the edge that makes cyc == c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start(input logic a, input logic b);
    reset = 1'b1; car_A = a; car_B = b; ped_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drain_check();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared (cyc=%0d)", mon_e.name, mon_e.cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; car_A = 1'b0; car_B = 1'b0; ped_req = 1'b0;

    // Only B waiting: minimum A green, yellow, clear, then B holds.
    start(1'b0, 1'b1);
    push("s1_rst",   0, 3'd0, 0,  1'b0);
    push("s1_ag7",   7, 3'd0, 7,  1'b0);
    push("s1_ay0",   8, 3'd1, 0,  1'b0);
    push("s1_ay2",  10, 3'd1, 2,  1'b0);
    push("s1_ac",   11, 3'd2, 0,  1'b0);
    push("s1_bg0",  12, 3'd3, 0,  1'b0);
    push("s1_bgsat",40, 3'd3, 19, 1'b0);
    goto(41);
    drain_check();

    // Both roads busy: each green maxes out at 20 cycles.
    start(1'b1, 1'b1);
    push("s2_ag19", 19, 3'd0, 19, 1'b0);
    push("s2_ay0",  20, 3'd1, 0,  1'b0);
    push("s2_ac",   23, 3'd2, 0,  1'b0);
    push("s2_bg0",  24, 3'd3, 0,  1'b0);
    push("s2_bg19", 43, 3'd3, 19, 1'b0);
    push("s2_by0",  44, 3'd4, 0,  1'b0);
    push("s2_ag0",  48, 3'd0, 0,  1'b0);
    goto(49);
    drain_check();

    // No demand: A holds, counter saturates.
    start(1'b0, 1'b0);
    push("s3_ag5",    5, 3'd0, 5,  1'b0);
    push("s3_ag18",  18, 3'd0, 18, 1'b0);
    push("s3_ag19",  19, 3'd0, 19, 1'b0);
    push("s3_ag100",100, 3'd0, 19, 1'b0);
    goto(101);
    drain_check();

    // Pedestrian request, then a second request during the walk.
    start(1'b0, 1'b0);
`ifdef PED_CROSSING_EN
    push("s4_c2",   2, 3'd0, 2,  1'b0);
    push("s4_pp3",  3, 3'd0, 3,  1'b1);
    push("s4_ag7",  7, 3'd0, 7,  1'b1);
    push("s4_ay0",  8, 3'd1, 0,  1'b1);
    push("s4_ac",  11, 3'd2, 0,  1'b1);
    push("s4_wk0", 12, 3'd6, 0,  1'b0);
    push("s4_wk2", 14, 3'd6, 2,  1'b0);
    push("s4_wk5", 17, 3'd6, 5,  1'b0);
    push("s4_bg0", 18, 3'd3, 0,  1'b0);
    push("s4_bg12",30, 3'd3, 12, 1'b0);
    push("s4_bg19",40, 3'd3, 19, 1'b0);
`else
    push("s4_c2",   2, 3'd0, 2,  1'b0);
    push("s4_pp3",  3, 3'd0, 3,  1'b0);
    push("s4_ag8",  8, 3'd0, 8,  1'b0);
    push("s4_ag12",12, 3'd0, 12, 1'b0);
    push("s4_ag18",18, 3'd0, 18, 1'b0);
    push("s4_ag30",30, 3'd0, 19, 1'b0);
    push("s4_ag40",40, 3'd0, 19, 1'b0);
`endif
    goto(2);  ped_req = 1'b1;
    goto(3);  ped_req = 1'b0;
    goto(13); ped_req = 1'b1;
    goto(14); ped_req = 1'b0;
    goto(41);
    drain_check();

    // Reset asserted asynchronously in B yellow with a request pending.
    start(1'b0, 1'b1);
    push("s6_bg0", 12, 3'd3, 0, 1'b0);
`ifdef PED_CROSSING_EN
    push("s6_pp",  14, 3'd3, 2, 1'b1);
    push("s6_bg7", 19, 3'd3, 7, 1'b1);
    push("s6_by0", 20, 3'd4, 0, 1'b1);
`else
    push("s6_pp",  14, 3'd3, 2, 1'b0);
    push("s6_bg8", 20, 3'd3, 8, 1'b0);
`endif
    goto(13); car_B = 1'b0; ped_req = 1'b1;
    goto(14); ped_req = 1'b0;
    goto(21);
    push_now("s6_arst", 3'd0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    drain_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
